// File: rtl/stp_rx_ctrl.sv
// ---------------------------------------------------------------------------
// stp_rx_ctrl
//
// Receive sequencer for an asynchronous serial link that uses an external
// serial-to-parallel shift register (shifts toward the LSB, serial input into
// the MSB). The block synchronizes the line, detects the start bit, centres
// sampling on each bit with a clock divider, strobes the shift register once
// per data bit, checks stop framing and hands each completed word to the
// consumer through a one-entry valid/ready buffer.
//
// Optional feature: define STP_RX_PARITY_EN to add an even-parity bit between
// the last data bit and the stop bit. Without it the frame is start, NUM_BITS
// data bits, stop, and parity_error is tied low.
//
// Parameters:
//   NUM_BITS      data bits per frame, equals the shift register width (2..16)
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//
// Ports:
//   clk              system clock
//   n_rst            asynchronous active-low reset
//   rx_line          raw serial line, idles high
//   sr_serial_in     synchronized line, to the shift register serial input
//   sr_shift_enable  one-cycle shift strobe to the shift register
//   sr_parallel      shift register parallel output
//   rx_data          received word, stable while rx_valid is high
//   rx_valid         word available
//   rx_ready         consumer takes the word when rx_valid && rx_ready
//   busy             receiver is not idle
//   framing_error    one-cycle pulse: stop bit sampled low
//   overrun_error    one-cycle pulse: word completed while buffer still full
//   parity_error     one-cycle pulse: parity mismatch (0 without the feature)
// ---------------------------------------------------------------------------
module stp_rx_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                rx_line,
    output logic                sr_serial_in,
    output logic                sr_shift_enable,
    input  logic [NUM_BITS-1:0] sr_parallel,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                busy,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(NUM_BITS + 1);

    // Midpoint of the start bit; every later sample lands one full bit after it.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef STP_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    // Two-flop synchronizer plus one flop of history for edge detection.
    // All three reset high so a released reset never looks like a start edge.
    logic sync1_q, sync2_q, sync_prev_q;
    logic sync;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bitn_q, bitn_d;
    logic [NUM_BITS-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                framing_error_q, framing_error_d;
    logic                overrun_error_q, overrun_error_d;

    logic shift_en;
    logic stop_sample;
    logic parity_ok;
    logic deliver;

`ifdef STP_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
    logic parity_error_q, parity_error_d;
`endif

    assign sync = sync2_q;

    // ---------------------------------------------------------------------
    // Bit-timing state machine
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
`ifdef STP_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sync_prev_q && !sync) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MID) begin
                    cnt_d  = '0;
                    bitn_d = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = sync ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    shift_en = 1'b1;
                    cnt_d    = '0;
                    bitn_d   = bitn_q + 1'b1;
                    if (bitn_q == BIT_LAST) begin
`ifdef STP_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef STP_RX_PARITY_EN
            ST_PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    parity_bit_d = sync;
                    cnt_d        = '0;
                    state_d      = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    stop_sample = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Word delivery and error pulses
    // ---------------------------------------------------------------------
`ifdef STP_RX_PARITY_EN
    // Even parity: data bits and parity bit together must XOR to zero.
    assign parity_ok = ~(^sr_parallel ^ parity_bit_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign deliver = stop_sample && sync && parity_ok;

    always_comb begin
        rx_data_d       = rx_data_q;
        rx_valid_d      = rx_valid_q;
        framing_error_d = stop_sample && !sync;
        overrun_error_d = deliver && rx_valid_q && !rx_ready;
`ifdef STP_RX_PARITY_EN
        parity_error_d  = stop_sample && !parity_ok;
`endif

        if (deliver) begin
            // A full buffer that is not being drained keeps the old word;
            // a same-cycle accept makes room for the new one.
            if (!(rx_valid_q && !rx_ready)) begin
                rx_data_d  = sr_parallel;
                rx_valid_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            sync_prev_q     <= 1'b1;
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            bitn_q          <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            sync1_q         <= rx_line;
            sync2_q         <= sync1_q;
            sync_prev_q     <= sync2_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bitn_q          <= bitn_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

`ifdef STP_RX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_bit_q   <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            parity_bit_q   <= parity_bit_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign sr_serial_in    = sync;
    assign sr_shift_enable = shift_en;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign busy            = (state_q != ST_IDLE);
    assign framing_error   = framing_error_q;
    assign overrun_error   = overrun_error_q;

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stp_rx_ctrl
//
// Self-checking bench for stp_rx_ctrl with NUM_BITS=8, CLKS_PER_BIT=16.
// Contains a behavioural model of the external shift register, a monitor that
// counts strobes / pulses / accepted words on the falling clock edge, a table
// of directed frames, hand-written corner sequences (false start, reset
// mid-frame, parity when STP_RX_PARITY_EN is defined) and a randomized run
// checked against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_stp_rx_ctrl;

    localparam int N   = 8;
    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int GAP = 6;
    // Line fall -> first strobe: two synchronizer flops plus the edge-history
    // flop, then the midpoint of the start bit, then one full bit.
    localparam int FIRST_LAT = 3 + (H - 1) + C;

`ifdef STP_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic         rx_line;
    logic         rx_ready;
    logic         sr_serial_in;
    logic         sr_shift_enable;
    logic [N-1:0] sr_parallel = '0;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         framing_error;
    logic         overrun_error;
    logic         parity_error;

    // When set, the next frame is sent with its parity bit inverted.
    logic par_flip = 1'b0;

    always #5 clk = ~clk;

    stp_rx_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(C)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .rx_line         (rx_line),
        .sr_serial_in    (sr_serial_in),
        .sr_shift_enable (sr_shift_enable),
        .sr_parallel     (sr_parallel),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .busy            (busy),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error),
        .parity_error    (parity_error)
    );

    // External shift register: shifts toward the LSB, serial input into MSB.
    always @(posedge clk) begin
        if (sr_shift_enable) sr_parallel <= {sr_serial_in, sr_parallel[N-1:1]};
    end

    // ---------------------------------------------------------------------
    // Checking infrastructure
    // ---------------------------------------------------------------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor, sampled on the falling edge (mid-cycle).
    int           neg_n          = 0;
    logic         line_prev      = 1'b1;
    int           fall_n         = 0;
    int           last_strobe_n  = -1;
    int           first_lat      = -1;
    int           shift_cnt      = 0;
    int           gap_bad        = 0;
    int           fe_cnt         = 0;
    int           oe_cnt         = 0;
    int           pe_cnt         = 0;
    logic [N-1:0] got_q[$];

    always @(negedge clk) begin
        neg_n++;
        if (line_prev && !rx_line && !busy) begin
            fall_n        = neg_n;
            last_strobe_n = -1;
        end
        line_prev = rx_line;
        if (sr_shift_enable) begin
            shift_cnt++;
            if (last_strobe_n < 0) first_lat = neg_n - fall_n;
            else if (neg_n - last_strobe_n != C) gap_bad++;
            last_strobe_n = neg_n;
        end
        if (framing_error) fe_cnt++;
        if (overrun_error) oe_cnt++;
        if (parity_error)  pe_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic clear_counts();
        shift_cnt = 0;
        gap_bad   = 0;
        first_lat = -1;
        fe_cnt    = 0;
        oe_cnt    = 0;
        pe_cnt    = 0;
        got_q.delete();
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx_line = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_bit);
        hold_bit(1'b0);
        for (int i = 0; i < N; i++) hold_bit(d[i]);
`ifdef STP_RX_PARITY_EN
        hold_bit(^d ^ par_flip);
`endif
        hold_bit(stop_bit);
        rx_line = 1'b1;
        tick(GAP);
    endtask

    // ---------------------------------------------------------------------
    // Directed frame table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [N-1:0] data;
        logic         stop;
        logic         ready;
        logic [N-1:0] exp_data;
        logic         exp_valid;
        int           exp_acc;
        int           exp_fe;
        int           exp_oe;
    } vec_t;

    vec_t vecs[5];

    // Reference-model state for the randomized run.
    logic [N-1:0] exp_q[$];
    logic [N-1:0] m_buf;
    bit           m_valid;
    int           exp_fe, exp_oe, exp_pe;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, ready: 1'b1, exp_data: 8'hA5, exp_valid: 1'b0, exp_acc: 1, exp_fe: 0, exp_oe: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, ready: 1'b1, exp_data: 8'hA5, exp_valid: 1'b0, exp_acc: 0, exp_fe: 1, exp_oe: 0};
        vecs[2] = '{data: 8'h11, stop: 1'b1, ready: 1'b1, exp_data: 8'h11, exp_valid: 1'b0, exp_acc: 1, exp_fe: 0, exp_oe: 0};
        vecs[3] = '{data: 8'h3C, stop: 1'b1, ready: 1'b0, exp_data: 8'h3C, exp_valid: 1'b1, exp_acc: 0, exp_fe: 0, exp_oe: 0};
        vecs[4] = '{data: 8'hC3, stop: 1'b1, ready: 1'b0, exp_data: 8'h3C, exp_valid: 1'b1, exp_acc: 0, exp_fe: 0, exp_oe: 1};

        // ---- reset state ----
        n_rst    = 1'b0;
        rx_line  = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("rst_rx_data",      32'(rx_data), 0);
        check("rst_rx_valid",     32'(rx_valid), 0);
        check("rst_shift_enable", 32'(sr_shift_enable), 0);
        check("rst_busy",         32'(busy), 0);
        check("rst_serial_in",    32'(sr_serial_in), 1);
        check("rst_errors",       {29'd0, framing_error, overrun_error, parity_error}, 0);
        n_rst = 1'b1;
        tick(4);

        // ---- directed table ----
        foreach (vecs[v]) begin
            clear_counts();
            par_flip = 1'b0;
            rx_ready = vecs[v].ready;
            send_frame(vecs[v].data, vecs[v].stop);
            check($sformatf("vec%0d_rx_data", v),  32'(rx_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_rx_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_accepts", v),  got_q.size(), vecs[v].exp_acc);
            if (got_q.size() > 0)
                check($sformatf("vec%0d_acc_word", v), 32'(got_q[0]), 32'(vecs[v].data));
            check($sformatf("vec%0d_framing", v),  fe_cnt, vecs[v].exp_fe);
            check($sformatf("vec%0d_overrun", v),  oe_cnt, vecs[v].exp_oe);
            check($sformatf("vec%0d_parity", v),   pe_cnt, 0);
            check($sformatf("vec%0d_shifts", v),   shift_cnt, N);
            check($sformatf("vec%0d_spacing", v),  gap_bad, 0);
            check($sformatf("vec%0d_first_lat", v), first_lat, FIRST_LAT);
            check($sformatf("vec%0d_busy_end", v), 32'(busy), 0);
        end

        // ---- drain after overrun: exactly one accept clears rx_valid ----
        got_q.delete();
        rx_ready = 1'b1;
        tick(1);
        check("drain_valid",   32'(rx_valid), 0);
        check("drain_accepts", got_q.size(), 1);
        if (got_q.size() > 0) check("drain_word", 32'(got_q[0]), 32'h3C);
        tick(2);
        check("drain_no_more", got_q.size(), 1);

        // ---- false start: line low 3 cycles ----
        clear_counts();
        rx_line = 1'b0;
        tick(3);
        rx_line = 1'b1;
        check("false_busy_high", 32'(busy), 1);
        tick(2 * C);
        check("false_busy_low", 32'(busy), 0);
        check("false_shifts",   shift_cnt, 0);
        check("false_valid",    32'(rx_valid), 0);
        check("false_framing",  fe_cnt, 0);

        // ---- reset after 4th data strobe of 0xFF ----
        clear_counts();
        rx_line = 1'b0;
        tick(C);
        rx_line = 1'b1;
        for (int i = 0; i < 10 * C && shift_cnt < 4; i++) tick(1);
        check("mid_rst_strobes", shift_cnt, 4);
        n_rst = 1'b0;
        #1;
        check("mid_rst_rx_data",  32'(rx_data), 0);
        check("mid_rst_valid",    32'(rx_valid), 0);
        check("mid_rst_busy",     32'(busy), 0);
        check("mid_rst_shift",    32'(sr_shift_enable), 0);
        check("mid_rst_serial",   32'(sr_serial_in), 1);
        check("mid_rst_errors",   {29'd0, framing_error, overrun_error, parity_error}, 0);
        tick(3);
        n_rst = 1'b1;
        tick(3);
        clear_counts();
        send_frame(8'h5A, 1'b1);
        check("post_rst_accepts", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_word", 32'(got_q[0]), 32'h5A);
        check("post_rst_framing", fe_cnt, 0);

`ifdef STP_RX_PARITY_EN
        // ---- parity: 0x07 needs parity bit 1 for even parity ----
        clear_counts();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        check("par_bad_pulse",   pe_cnt, 1);
        check("par_bad_accepts", got_q.size(), 0);
        check("par_bad_framing", fe_cnt, 0);
        clear_counts();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        check("par_good_pulse",   pe_cnt, 0);
        check("par_good_accepts", got_q.size(), 1);
        if (got_q.size() > 0) check("par_good_word", 32'(got_q[0]), 32'h07);
`endif

        // ---- randomized frames against a frame-level model ----
        clear_counts();
        exp_q.delete();
        m_valid = 1'b0;
        m_buf   = '0;
        exp_fe  = 0;
        exp_oe  = 0;
        exp_pe  = 0;
        for (int f = 0; f < 24; f++) begin
            logic [N-1:0] d;
            logic         stop, rdy, bad_par, good;
            d       = N'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            rdy     = 1'($urandom_range(0, 1));
            par_flip = PAR_EN && ($urandom_range(0, 3) == 0);
            bad_par = par_flip && PAR_EN;
            good    = stop && !bad_par;
            // A ready consumer takes any buffered word before this frame lands.
            if (rdy && m_valid) begin
                exp_q.push_back(m_buf);
                m_valid = 1'b0;
            end
            if (!stop) exp_fe++;
            if (bad_par) exp_pe++;
            if (good) begin
                if (m_valid) exp_oe++;
                else if (rdy) exp_q.push_back(d);
                else begin
                    m_buf   = d;
                    m_valid = 1'b1;
                end
            end
            rx_ready = rdy;
            send_frame(d, stop);
        end
        rx_ready = 1'b1;
        tick(4);
        if (m_valid) exp_q.push_back(m_buf);
        par_flip = 1'b0;

        check("rand_accepts", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("rand_framing", fe_cnt, exp_fe);
        check("rand_overrun", oe_cnt, exp_oe);
        check("rand_parity",  pe_cnt, exp_pe);
        check("rand_shifts",  shift_cnt, 24 * N);
        check("rand_spacing", gap_bad, 0);
        check("rand_valid_end", 32'(rx_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
